// File: rtl/vx_tex_sampler.sv
// Texture filter: unpacks four texels per lane to RGBA8888 and blends bilinearly or passes texel 0; 3-cycle latency.
// Backpressure: every stage holds while rsp_valid & ~rsp_ready, and req_ready = ~stall. Option macro: TEX_SAMPLER_PERF_EN.
module vx_tex_sampler #(
   parameter int REQ_INFOW = 1,
   parameter int NUM_LANES = 1,
   parameter int FRAC_BITS = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             req_valid,
   input  logic [NUM_LANES-1:0]             req_mask,
   input  logic [1:0]                       req_format,
   input  logic                             req_filter,
   input  logic [NUM_LANES*2*FRAC_BITS-1:0] req_blends,
   input  logic [NUM_LANES*4*32-1:0]        req_data,
   input  logic [REQ_INFOW-1:0]             req_info,
   output logic                             req_ready,
   output logic                             rsp_valid,
   output logic [NUM_LANES-1:0]             rsp_mask,
   output logic [NUM_LANES*32-1:0]          rsp_data,
   output logic [REQ_INFOW-1:0]             rsp_info,
   input  logic                             rsp_ready
`ifdef TEX_SAMPLER_PERF_EN
   ,
   output logic [31:0]                      perf_stalls
`endif
);

   localparam int LW = 9 + FRAC_BITS;

   function automatic logic [31:0] f_unpack(input logic [1:0] fmt, input logic [31:0] x);
      case (fmt)
         2'd0:    return x;
         2'd1:    return {8'hFF, x[4:0], x[4:2], x[10:5], x[10:9], x[15:11], x[15:13]};
         2'd2:    return {x[3:0], x[3:0], x[7:4], x[7:4], x[11:8], x[11:8], x[15:12], x[15:12]};
         default: return {8'hFF, x[7:0], x[7:0], x[7:0]};
      endcase
   endfunction

   // Rounded fixed-point blend; f=0 yields p exactly, so point sampling reuses this path with zero weights.
   function automatic logic [7:0] f_lerp8(input logic [7:0] p, input logic [7:0] q,
                                          input logic [FRAC_BITS-1:0] f);
      logic [LW-1:0] w_sum;
      w_sum = LW'(p) * (LW'(2**FRAC_BITS) - LW'(f)) + LW'(q) * LW'(f) + LW'(2**(FRAC_BITS-1));
      return w_sum[FRAC_BITS +: 8];
   endfunction

   function automatic logic [31:0] f_lerp32(input logic [31:0] p, input logic [31:0] q,
                                            input logic [FRAC_BITS-1:0] f);
      logic [31:0] w_res;
      for (int c = 0; c < 4; c++)
         w_res[c*8 +: 8] = f_lerp8(p[c*8 +: 8], q[c*8 +: 8], f);
      return w_res;
   endfunction

   logic                                             w_stall;
   logic [NUM_LANES-1:0][3:0][31:0]                  w_unp;
   logic [NUM_LANES-1:0][31:0]                       w_top;
   logic [NUM_LANES-1:0][31:0]                       w_bot;
   logic [NUM_LANES-1:0][FRAC_BITS-1:0]              w_v;
   logic [NUM_LANES-1:0][31:0]                       w_out;

   logic                                             r_s0_vld;
   logic [NUM_LANES-1:0]                             r_s0_mask;
   logic [REQ_INFOW-1:0]                             r_s0_info;
   logic                                             r_s0_filter;
   logic [NUM_LANES-1:0][1:0][FRAC_BITS-1:0]         r_s0_bl;
   logic [NUM_LANES-1:0][3:0][31:0]                  r_s0_tex;

   logic                                             r_s1_vld;
   logic [NUM_LANES-1:0]                             r_s1_mask;
   logic [REQ_INFOW-1:0]                             r_s1_info;
   logic                                             r_s1_filter;
   logic [NUM_LANES-1:0][FRAC_BITS-1:0]              r_s1_v;
   logic [NUM_LANES-1:0][31:0]                       r_s1_top;
   logic [NUM_LANES-1:0][31:0]                       r_s1_bot;

   logic                                             r_rsp_vld;
   logic [NUM_LANES-1:0]                             r_rsp_mask;
   logic [REQ_INFOW-1:0]                             r_rsp_info;
   logic [NUM_LANES-1:0][31:0]                       r_rsp_data;

   assign w_stall   = r_rsp_vld & ~rsp_ready;
   assign req_ready = ~w_stall;
   assign rsp_valid = r_rsp_vld;
   assign rsp_mask  = r_rsp_mask;
   assign rsp_info  = r_rsp_info;
   assign rsp_data  = r_rsp_data;

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++)
         for (int t = 0; t < 4; t++)
            w_unp[l][t] = f_unpack(req_format, req_data[(l*4+t)*32 +: 32]);
   end

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         w_top[l] = f_lerp32(r_s0_tex[l][0], r_s0_tex[l][1], r_s0_filter ? r_s0_bl[l][0] : '0);
         w_bot[l] = f_lerp32(r_s0_tex[l][2], r_s0_tex[l][3], r_s0_filter ? r_s0_bl[l][0] : '0);
         w_v[l]   = r_s0_filter ? r_s0_bl[l][1] : '0;
      end
   end

   // Inactive lanes are zeroed on the way out; their mask bit still travels unchanged.
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++)
         w_out[l] = r_s1_mask[l] ? f_lerp32(r_s1_top[l], r_s1_bot[l], r_s1_v[l]) : 32'h0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s0_vld    <= 1'b0;
         r_s0_mask   <= '0;
         r_s0_info   <= '0;
         r_s0_filter <= 1'b0;
         r_s0_bl     <= '0;
         r_s0_tex    <= '0;
         r_s1_vld    <= 1'b0;
         r_s1_mask   <= '0;
         r_s1_info   <= '0;
         r_s1_filter <= 1'b0;
         r_s1_v      <= '0;
         r_s1_top    <= '0;
         r_s1_bot    <= '0;
         r_rsp_vld   <= 1'b0;
         r_rsp_mask  <= '0;
         r_rsp_info  <= '0;
         r_rsp_data  <= '0;
      end else if (!w_stall) begin
         r_s0_vld    <= req_valid;
         r_s0_mask   <= req_mask;
         r_s0_info   <= req_info;
         r_s0_filter <= req_filter;
         r_s0_bl     <= req_blends;
         r_s0_tex    <= w_unp;
         r_s1_vld    <= r_s0_vld;
         r_s1_mask   <= r_s0_mask;
         r_s1_info   <= r_s0_info;
         r_s1_filter <= r_s0_filter;
         r_s1_v      <= w_v;
         r_s1_top    <= w_top;
         r_s1_bot    <= w_bot;
         r_rsp_vld   <= r_s1_vld;
         r_rsp_mask  <= r_s1_mask;
         r_rsp_info  <= r_s1_info;
         r_rsp_data  <= w_out;
      end
   end

`ifdef TEX_SAMPLER_PERF_EN
   logic [31:0] r_perf_stalls;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_perf_stalls <= '0;
      else if (w_stall && (r_perf_stalls != 32'hFFFF_FFFF))
         r_perf_stalls <= r_perf_stalls + 32'd1;
   end

   assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_tex_sampler.sv
// Bench for vx_tex_sampler: directed scenarios plus a randomized stream scored against an arithmetic model.
module tb_vx_tex_sampler;
   localparam int NL = 4;
   localparam int FB = 8;
   localparam int IW = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               req_valid;
   logic [NL-1:0]      req_mask;
   logic [1:0]         req_format;
   logic               req_filter;
   logic [NL*2*FB-1:0] req_blends;
   logic [NL*4*32-1:0] req_data;
   logic [IW-1:0]      req_info;
   logic               req_ready;
   logic               rsp_valid;
   logic [NL-1:0]      rsp_mask;
   logic [NL*32-1:0]   rsp_data;
   logic [IW-1:0]      rsp_info;
   logic               rsp_ready;
`ifdef TEX_SAMPLER_PERF_EN
   logic [31:0]        perf_stalls;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [NL*32-1:0] data;
      logic [NL-1:0]    mask;
      logic [IW-1:0]    info;
   } exp_t;
   exp_t exp_q[$];

   vx_tex_sampler #(.REQ_INFOW(IW), .NUM_LANES(NL), .FRAC_BITS(FB)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_mask(req_mask), .req_format(req_format), .req_filter(req_filter),
      .req_blends(req_blends), .req_data(req_data), .req_info(req_info), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data), .rsp_info(rsp_info),
      .rsp_ready(rsp_ready)
`ifdef TEX_SAMPLER_PERF_EN
      , .perf_stalls(perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int m_chan(input logic [31:0] c, input int i);
      return int'((c >> (8*i)) & 32'hFF);
   endfunction

   function automatic logic [31:0] m_pack(input int r, input int g, input int b, input int a);
      logic [31:0] w;
      w[7:0] = r[7:0]; w[15:8] = g[7:0]; w[23:16] = b[7:0]; w[31:24] = a[7:0];
      return w;
   endfunction

   function automatic logic [31:0] m_unpack(input logic [1:0] fmt, input logic [31:0] x);
      int r5, g6, b5;
      case (fmt)
         2'd0: return x;
         2'd1: begin
            r5 = int'((x >> 11) & 31); g6 = int'((x >> 5) & 63); b5 = int'(x & 31);
            return m_pack((r5 << 3) | (r5 >> 2), (g6 << 2) | (g6 >> 4), (b5 << 3) | (b5 >> 2), 255);
         end
         2'd2: return m_pack(int'((x >> 12) & 15) * 17, int'((x >> 8) & 15) * 17,
                             int'((x >> 4) & 15) * 17, int'(x & 15) * 17);
         default: return m_pack(int'(x & 255), int'(x & 255), int'(x & 255), 255);
      endcase
   endfunction

   function automatic int m_lerp(input int p, input int q, input int f);
      return ((p * ((1 << FB) - f) + q * f + (1 << (FB - 1))) >> FB) & 255;
   endfunction

   function automatic logic [31:0] m_sample(input logic [1:0] fmt, input logic filt, input int u, input int v,
                                            input logic [31:0] t0, input logic [31:0] t1,
                                            input logic [31:0] t2, input logic [31:0] t3);
      logic [31:0] c0, c1, c2, c3;
      int o[4];
      c0 = m_unpack(fmt, t0); c1 = m_unpack(fmt, t1); c2 = m_unpack(fmt, t2); c3 = m_unpack(fmt, t3);
      if (!filt) return c0;
      for (int i = 0; i < 4; i++) begin
         int top, bot;
         top  = m_lerp(m_chan(c0, i), m_chan(c1, i), u);
         bot  = m_lerp(m_chan(c2, i), m_chan(c3, i), u);
         o[i] = m_lerp(top, bot, v);
      end
      return m_pack(o[0], o[1], o[2], o[3]);
   endfunction

   function automatic logic [NL*32-1:0] m_expect(input logic [NL-1:0] msk, input logic [1:0] fmt, input logic filt,
                                                 input logic [NL*2*FB-1:0] bl, input logic [NL*4*32-1:0] dat);
      logic [NL*32-1:0] r;
      r = '0;
      for (int l = 0; l < NL; l++)
         if (msk[l])
            r[l*32 +: 32] = m_sample(fmt, filt, int'(bl[(2*l)*FB +: FB]), int'(bl[(2*l+1)*FB +: FB]),
                                     dat[(4*l)*32 +: 32], dat[(4*l+1)*32 +: 32],
                                     dat[(4*l+2)*32 +: 32], dat[(4*l+3)*32 +: 32]);
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [NL*4*32-1:0] rand_data();
      logic [NL*4*32-1:0] d;
      for (int i = 0; i < NL*4; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [NL*2*FB-1:0] rand_bl();
      logic [NL*2*FB-1:0] b;
      for (int i = 0; i < NL*2; i++) b[i*FB +: FB] = FB'($urandom);
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [NL-1:0] msk, input logic [1:0] fmt, input logic filt,
                          input logic [NL*2*FB-1:0] bl, input logic [NL*4*32-1:0] dat, input logic [IW-1:0] inf);
      req_mask = msk; req_format = fmt; req_filter = filt; req_blends = bl; req_data = dat; req_info = inf;
   endtask

   // Sends one request with rsp_ready held high and returns what came out plus edges-to-visibility.
   task automatic run_one(input logic [NL-1:0] msk, input logic [1:0] fmt, input logic filt,
                          input logic [NL*2*FB-1:0] bl, input logic [NL*4*32-1:0] dat, input logic [IW-1:0] inf,
                          output logic [NL*32-1:0] d, output logic [NL-1:0] m, output logic [IW-1:0] i,
                          output int lat, output logic rdy);
      rsp_ready = 1'b1;
      set_req(msk, fmt, filt, bl, dat, inf);
      req_valid = 1'b1;
      #1;
      rdy = req_ready;
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         tick();
         lat++;
      end
      d = rsp_data; m = rsp_mask; i = rsp_info;
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      set_req('0, 2'd0, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_mask, rsp_info} !== '0 || rsp_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b mask=%h info=%h data=%h, required all zero",
                  rsp_valid, rsp_mask, rsp_info, rsp_data);
      end
`ifdef TEX_SAMPLER_PERF_EN
      checks++;
      if (perf_stalls !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf: got %0d required 0", perf_stalls);
      end
`endif
      reset = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_req_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_point_rgba();
      logic [NL*4*32-1:0] dat;
      logic [NL*32-1:0] d; logic [NL-1:0] m; logic [IW-1:0] inf; int lat; logic rdy;
      dat = rand_data();
      dat[31:0] = 32'h11223344;
      run_one(4'b0001, 2'd0, 1'b0, rand_bl(), dat, 8'hA5, d, m, inf, lat, rdy);
      checks++;
      if (rdy !== 1'b1 || lat != 3) begin
         errors++;
         $display("FAIL point_latency: ready=%b latency=%0d, required ready=1 latency=3", rdy, lat);
      end
      checks++;
      if (d[31:0] !== 32'h11223344 || d[NL*32-1:32] !== '0) begin
         errors++;
         $display("FAIL point_rgba8888: got %h required lane0=11223344 others 0", d);
      end
      checks++;
      if (m !== 4'b0001 || inf !== 8'hA5) begin
         errors++;
         $display("FAIL point_mask_info: mask=%b info=%h required 0001 a5", m, inf);
      end
   endtask

   task automatic test_bilinear();
      logic [NL*4*32-1:0] dat;
      logic [NL*2*FB-1:0] bl;
      logic [NL*32-1:0] d, e; logic [NL-1:0] m; logic [IW-1:0] inf; int lat; logic rdy;
      logic [NL-1:0] msk; logic [1:0] fmt;
      dat = rand_data();
      dat[31:0] = 32'h0; dat[63:32] = 32'hFFFF_FFFF; dat[95:64] = 32'h0; dat[127:96] = 32'hFFFF_FFFF;
      bl = rand_bl();
      bl[7:0] = 8'h80; bl[15:8] = 8'h80;
      run_one(4'b0001, 2'd0, 1'b1, bl, dat, 8'h01, d, m, inf, lat, rdy);
      checks++;
      if (d[31:0] !== 32'h8080_8080 || lat != 3) begin
         errors++;
         $display("FAIL bilinear_half: got %h lat=%0d required 80808080 lat=3", d[31:0], lat);
      end
      bl[7:0] = 8'h00; bl[15:8] = 8'h00;
      run_one(4'b0001, 2'd0, 1'b1, bl, dat, 8'h02, d, m, inf, lat, rdy);
      checks++;
      if (d[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL bilinear_zero: got %h required 00000000", d[31:0]);
      end
      for (int k = 0; k < 4; k++) begin
         dat = rand_data(); bl = rand_bl(); msk = 4'hF; fmt = 2'($urandom_range(0, 3));
         e = m_expect(msk, fmt, 1'b1, bl, dat);
         run_one(msk, fmt, 1'b1, bl, dat, 8'(k), d, m, inf, lat, rdy);
         checks++;
         if (d !== e) begin
            errors++;
            $display("FAIL bilinear_random fmt=%0d: got %h required %h", fmt, d, e);
         end
      end
   endtask

   task automatic test_formats();
      logic [1:0]  fmts[3] = '{2'd1, 2'd2, 2'd3};
      logic [31:0] t0s[3]  = '{32'h0000_F800, 32'h0000_F00F, 32'h0000_005A};
      logic [31:0] exps[3] = '{32'hFF00_00FF, 32'hFF00_00FF, 32'hFF5A_5A5A};
      logic [NL*4*32-1:0] dat;
      logic [NL*32-1:0] d; logic [NL-1:0] m; logic [IW-1:0] inf; int lat; logic rdy;
      for (int k = 0; k < 3; k++) begin
         dat = rand_data();
         dat[31:0] = t0s[k];
         run_one(4'b0001, fmts[k], 1'b0, rand_bl(), dat, 8'h10, d, m, inf, lat, rdy);
         checks++;
         if (d[31:0] !== exps[k]) begin
            errors++;
            $display("FAIL format_%0d: got %h required %h", fmts[k], d[31:0], exps[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [NL*32-1:0] e[3];
      logic [NL*4*32-1:0] dat; logic [NL*2*FB-1:0] bl; logic [1:0] fmt; logic filt;
      int got;
`ifdef TEX_SAMPLER_PERF_EN
      logic [31:0] p0;
      p0 = perf_stalls;
`endif
      got = 0;
      for (int c = 0; c < 16; c++) begin
         rsp_ready = !(c >= 3 && c <= 7);
         if (c < 3) begin
            dat = rand_data(); bl = rand_bl(); fmt = 2'($urandom_range(0, 3)); filt = 1'($urandom);
            set_req(4'hF, fmt, filt, bl, dat, 8'(c));
            e[c] = m_expect(4'hF, fmt, filt, bl, dat);
            req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (c < 3) begin
            checks++;
            if (req_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_accept c=%0d: req_ready=%b required 1", c, req_ready);
            end
         end
         if (c >= 3 && c <= 7) begin
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== e[0] || rsp_info !== 8'd0) begin
               errors++;
               $display("FAIL b2b_stall c=%0d: req_ready=%b valid=%b info=%h data=%h required 0 1 00 %h",
                        c, req_ready, rsp_valid, rsp_info, rsp_data, e[0]);
            end
         end
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (got >= 3 || rsp_data !== e[got] || rsp_info !== 8'(got)) begin
               errors++;
               $display("FAIL b2b_order n=%0d: info=%h data=%h", got, rsp_info, rsp_data);
            end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d responses required 3", got);
      end
`ifdef TEX_SAMPLER_PERF_EN
      checks++;
      if (perf_stalls - p0 !== 32'd5) begin
         errors++;
         $display("FAIL b2b_perf_stalls: got %0d required 5", perf_stalls - p0);
      end
`endif
   endtask

   task automatic test_mask();
      logic [NL*4*32-1:0] dat;
      logic [NL*32-1:0] d; logic [NL-1:0] m; logic [IW-1:0] inf; int lat; logic rdy;
      dat = rand_data();
      run_one(4'b0101, 2'd0, 1'b0, rand_bl(), dat, 8'h33, d, m, inf, lat, rdy);
      checks++;
      if (m !== 4'b0101) begin
         errors++;
         $display("FAIL mask_pass: got %b required 0101", m);
      end
      checks++;
      if (d[63:32] !== 32'h0 || d[127:96] !== 32'h0) begin
         errors++;
         $display("FAIL mask_zero_lanes: lane1=%h lane3=%h required 0", d[63:32], d[127:96]);
      end
      checks++;
      if (d[31:0] !== dat[31:0] || d[95:64] !== dat[287:256]) begin
         errors++;
         $display("FAIL mask_active_lanes: lane0=%h lane2=%h required %h %h", d[31:0], d[95:64], dat[31:0], dat[287:256]);
      end
      run_one(4'b0000, 2'd3, 1'b1, rand_bl(), rand_data(), 8'h44, d, m, inf, lat, rdy);
      checks++;
      if (lat != 3 || d !== '0 || m !== 4'b0000 || inf !== 8'h44) begin
         errors++;
         $display("FAIL mask_empty: lat=%0d mask=%b info=%h data=%h required 3 0000 44 zero", lat, m, inf, d);
      end
   endtask

   task automatic test_async_reset();
      int seen;
      rsp_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         set_req(4'hF, 2'd0, 1'b0, rand_bl(), rand_data(), 8'(8'h70 + c));
         req_valid = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: rsp_valid=%b required 1", rsp_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_mask !== '0 || rsp_info !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b mask=%b info=%h data=%h required all zero",
                  rsp_valid, rsp_mask, rsp_info, rsp_data);
      end
      tick();
      tick();
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL async_no_ghost: %0d response cycles after reset, required 0", seen);
      end
   endtask

   task automatic test_random();
      logic [NL*4*32-1:0] dat; logic [NL*2*FB-1:0] bl; logic [NL-1:0] msk; logic [1:0] fmt; logic filt;
      logic [IW-1:0] inf;
      exp_t ex, held;
      logic prev_stall;
      int cyc;
      exp_q.delete();
      prev_stall = 1'b0;
      held = '0;
      for (int c = 0; c < 400; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         dat = rand_data(); bl = rand_bl(); msk = 4'($urandom); fmt = 2'($urandom_range(0, 3));
         filt = 1'($urandom); inf = 8'($urandom);
         set_req(msk, fmt, filt, bl, dat, inf);
         req_valid = ($urandom_range(0, 2) != 0);
         #1;
         if (prev_stall) begin
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_data, rsp_mask, rsp_info} !== held) begin
               errors++;
               $display("FAIL rand_hold c=%0d: valid=%b data=%h required held %h", c, rsp_valid, rsp_data, held.data);
            end
         end
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_unexpected c=%0d: data=%h with no request outstanding", c, rsp_data);
            end else begin
               ex = exp_q.pop_front();
               if (rsp_data !== ex.data || rsp_mask !== ex.mask || rsp_info !== ex.info) begin
                  errors++;
                  $display("FAIL rand_data c=%0d: got %h/%b/%h required %h/%b/%h",
                           c, rsp_data, rsp_mask, rsp_info, ex.data, ex.mask, ex.info);
               end
            end
         end
         if (req_valid && req_ready) begin
            ex.data = m_expect(msk, fmt, filt, bl, dat); ex.mask = msk; ex.info = inf;
            exp_q.push_back(ex);
         end
         prev_stall = rsp_valid && !rsp_ready;
         held = {rsp_data, rsp_mask, rsp_info};
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         #1;
         if (rsp_valid) begin
            ex = exp_q.pop_front();
            checks++;
            if (rsp_data !== ex.data || rsp_mask !== ex.mask || rsp_info !== ex.info) begin
               errors++;
               $display("FAIL rand_drain: got %h/%b/%h required %h/%b/%h",
                        rsp_data, rsp_mask, rsp_info, ex.data, ex.mask, ex.info);
            end
         end
         tick();
         cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_missing: %0d responses never arrived", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_point_rgba();
      test_bilinear();
      test_formats();
      test_back_to_back();
      test_mask();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
